bus_mux_arb: RTL and testbench
==============================

// Module: bus_mux_arb
// PURPOSE
//   Parametrised, registered datapath bus multiplexer for the multicycle processor.
//   Drives one of N source words (registers, G, DIN, memory) onto the shared bus.
//   Two modes: direct one-hot select from the control FSM, or round-robin arbitration among requesters.
//   Adds a one-cycle output register, a valid flag, source index, a sticky select-error flag and grant hold.
// PARAMETERS
//   W        16   bus / source word width in bits
//   N        11   number of sources (2..32)
//   IDX_W    4    width of source index; must equal $clog2(N)
// PORTS
//   clock      in   1      single clock, all state updates on rising edge
//   reset      in   1      asynchronous reset, active-high
//   mode       in   1      0 = direct one-hot select, 1 = round-robin arbitration
//   sel        in   N      one-hot source select (mode 0); bit k selects source k
//   req        in   N      per-source bus request (mode 1); bit k = source k
//   hold       in   1      mode 1: keep current grant while holder's req stays high
//   err_clr    in   1      clears sticky sel_err
//   src_data   in   N*W    source k on bits [k*W +: W]; narrower sources zero-extended by the driver
//   bus_out    out  W      registered bus value
//   bus_valid  out  1      bus_out was loaded from a source on the last edge
//   bus_src    out  IDX_W  index of source loaded into bus_out
//   grant      out  N      registered one-hot grant (mode 1); all-zero in mode 0
//   sel_err    out  1      sticky: multi-hot sel seen in mode 0
// BEHAVIOUR
//   Reset (async, immediate): bus_out=0, bus_valid=0, bus_src=0, grant=0, sel_err=0, rr_ptr=0.
//   Latency: 1 cycle; sel/req sampled at edge t, bus_out valid after edge t.
//   Mode 0 each edge:
//     - exactly one sel bit k: bus_out<=src[k], bus_src<=k, bus_valid<=1.
//     - sel==0: bus_out, bus_src hold; bus_valid<=0.
//     - >1 bit set: bus_out, bus_src hold; bus_valid<=0; sel_err<=1.
//     - grant<=0; rr_ptr unchanged.
//   Mode 1 each edge (arbiter states IDLE/GRANTED held in grant!=0):
//     - if hold=1 and grant!=0 and req[holder]=1: grant unchanged, bus_out<=src[holder],
//       bus_valid<=1, rr_ptr unchanged.
//     - else if req!=0: winner = first set req bit scanning rr_ptr, rr_ptr+1, .. N-1, 0, ..
//       (wraps); grant<=onehot(winner), bus_out<=src[winner], bus_src<=winner,
//       bus_valid<=1, rr_ptr<=winner+1 (N-1 wraps to 0).
//     - else: grant<=0, bus_valid<=0, bus_out/bus_src hold.
//     - sel ignored; sel_err not set.
//   sel_err: set and err_clr same edge -> set wins; err_clr alone -> 0.
//   Mode change takes effect at next edge; rr_ptr retained across mode changes.
//   Holder drops req while hold=1 -> normal arbitration that edge.
//   bus_src is an index only; indices >= N never produced.
// CONFIGURATION
//   BUS_MUX_PARITY_EN defined: extra output bus_par (1 bit), even parity (^bus_out),
//     registered on same edge as bus_out, reset 0, holds when bus_out holds.
//   Not defined: no bus_par port; no parity logic.
// TESTING
//   Reset mid-transfer (bus_out=16'h1234) -> all outputs 0 immediately, before next edge.
//   Mode 0, sel=11'b000_0000_0100, src2=16'hABCD -> next edge bus_out=ABCD, bus_src=2, bus_valid=1.
//   Mode 0, sel=0 then sel=11'b101 -> bus_out holds ABCD, bus_valid=0, sel_err=1; err_clr -> 0.
//   Mode 1, req=bits{1,5,9} held 4 edges, ptr=0 -> grants 1,5,9,1; bus_src tracks.
//   Mode 1, holder 5 with hold=1, req={5,9} for 3 edges -> grant stays 5; hold=0 -> grant 9.
//   BUS_MUX_PARITY_EN: load 16'h0007 -> bus_par=1; load 16'h0003 -> bus_par=0.

Source files
------------

// File: rtl/bus_mux_arb_if.sv
// bus_mux_arb_if
//   Bundles the control, source and result signals of the datapath bus
//   multiplexer / arbiter so that the processor datapath and the mux share one
//   connection. Clock and reset are plain ports on the module, not part of
//   this interface.
//
//   Signals
//     mode      1      0 = direct one-hot select, 1 = round-robin arbitration
//     sel       N      one-hot source select (mode 0)
//     req       N      per-source bus request (mode 1)
//     hold      1      keep the current grant while the holder keeps requesting
//     err_clr   1      clears the sticky select-error flag
//     src_data  N*W    source k on bits [k*W +: W]
//     bus_out   W      registered bus word
//     bus_valid 1      bus_out was loaded on the last edge
//     bus_src   IDX_W  index of the source held in bus_out
//     grant     N      registered one-hot grant (mode 1 only)
//     sel_err   1      sticky multi-hot select flag
//     bus_par   1      even parity of bus_out (only with BUS_MUX_PARITY_EN)
//
//   Modports
//     master : the control/datapath side that drives the requests
//     slave  : the bus_mux_arb side
interface bus_mux_arb_if #(
  parameter int W     = 16,
  parameter int N     = 11,
  parameter int IDX_W = 4
);
  logic             mode;
  logic [N-1:0]     sel;
  logic [N-1:0]     req;
  logic             hold;
  logic             err_clr;
  logic [N*W-1:0]   src_data;
  logic [W-1:0]     bus_out;
  logic             bus_valid;
  logic [IDX_W-1:0] bus_src;
  logic [N-1:0]     grant;
  logic             sel_err;
`ifdef BUS_MUX_PARITY_EN
  logic             bus_par;
`endif

  modport master (
    output mode, sel, req, hold, err_clr, src_data,
    input  bus_out, bus_valid, bus_src, grant, sel_err
`ifdef BUS_MUX_PARITY_EN
    , input bus_par
`endif
  );

  modport slave (
    input  mode, sel, req, hold, err_clr, src_data,
    output bus_out, bus_valid, bus_src, grant, sel_err
`ifdef BUS_MUX_PARITY_EN
    , output bus_par
`endif
  );
endinterface

// File: rtl/bus_mux_arb.sv
// bus_mux_arb
//   Registered bus multiplexer for the multicycle processor datapath. Each
//   rising clock edge one of N source words (registers, G, DIN, memory) may be
//   loaded into bus_out. In mode 0 the control FSM picks the source with a
//   one-hot sel; in mode 1 the sources request the bus and a round-robin
//   arbiter picks one, optionally keeping the grant while hold is asserted.
//
//   Ports
//     clock  in  1   rising-edge clock
//     reset  in  1   asynchronous, active-high reset
//     bif    slave modport of bus_mux_arb_if (see that file for the signals)
//
//   Configuration
//     BUS_MUX_PARITY_EN : when defined, adds bif.bus_par, the even parity of
//                         bus_out, registered together with bus_out.
module bus_mux_arb #(
  parameter int W     = 16,
  parameter int N     = 11,
  parameter int IDX_W = 4
) (
  input logic          clock,
  input logic          reset,
  bus_mux_arb_if.slave bif
);

  // The arbiter has no separate state register: it is GRANTED exactly when
  // some grant bit is set, IDLE otherwise.
  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_GRANTED = 1'b1;

  logic [W-1:0]     bus_out_q;
  logic             bus_valid_q;
  logic [IDX_W-1:0] bus_src_q;
  logic [N-1:0]     grant_q;
  logic             sel_err_q;
  logic [IDX_W-1:0] rr_ptr;

  logic [0:0]       arb_state;

  logic             sel_seen;
  logic             sel_multi;
  logic [IDX_W-1:0] sel_idx;

  logic [IDX_W-1:0] hold_idx;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  logic             do_load;
  logic [IDX_W-1:0] load_idx;
  logic [W-1:0]     load_word;
  logic [N-1:0]     grant_next;
  logic [IDX_W-1:0] ptr_next;
  logic             err_set;

  assign arb_state = (grant_q != '0) ? ARB_GRANTED : ARB_IDLE;

  // Decode sel: remember whether any bit is set, whether more than one is
  // set, and the index of the (last) set bit, which is the selected source
  // when exactly one bit is set.
  always_comb begin
    sel_seen  = 1'b0;
    sel_multi = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (bif.sel[k]) begin
        if (sel_seen) sel_multi = 1'b1;
        sel_seen = 1'b1;
        sel_idx  = IDX_W'(k);
      end
    end
  end

  // Encode the one-hot grant back to the index of the current holder.
  always_comb begin
    hold_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) hold_idx = IDX_W'(k);
    end
  end

  // Round-robin search: scan the request vector starting at rr_ptr and
  // wrapping past N-1 back to 0; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      if (!win_found && bif.req[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Decide what happens at the next edge: which source (if any) is loaded,
  // the next grant, the next round-robin pointer and whether sel_err is set.
  // A held grant is only honoured while its holder still requests; otherwise
  // the arbiter falls through to a normal round-robin decision that edge.
  always_comb begin
    do_load    = 1'b0;
    load_idx   = bus_src_q;
    grant_next = '0;
    ptr_next   = rr_ptr;
    err_set    = 1'b0;
    if (!bif.mode) begin
      if (sel_seen && !sel_multi) begin
        do_load  = 1'b1;
        load_idx = sel_idx;
      end
      err_set = sel_multi;
    end else if (arb_state == ARB_GRANTED && bif.hold && bif.req[hold_idx]) begin
      do_load    = 1'b1;
      load_idx   = hold_idx;
      grant_next = grant_q;
    end else if (win_found) begin
      do_load    = 1'b1;
      load_idx   = win_idx;
      grant_next = {{(N-1){1'b0}}, 1'b1} << win_idx;
      ptr_next   = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Pick the word of the chosen source out of the flattened source bus.
  always_comb begin
    load_word = '0;
    for (int k = 0; k < N; k++) begin
      if (load_idx == IDX_W'(k)) load_word = bif.src_data[k*W +: W];
    end
  end

  // Output and arbiter registers. bus_out and bus_src only change when a
  // source is actually loaded; bus_valid reports whether that happened.
  // sel_err is sticky, and a new select error beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      grant_q     <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      bus_valid_q <= do_load;
      if (do_load) begin
        bus_out_q <= load_word;
        bus_src_q <= load_idx;
      end
      grant_q <= grant_next;
      rr_ptr  <= ptr_next;
      if (err_set) begin
        sel_err_q <= 1'b1;
      end else if (bif.err_clr) begin
        sel_err_q <= 1'b0;
      end
    end
  end

`ifdef BUS_MUX_PARITY_EN
  logic bus_par_q;

  // Parity is computed from the incoming word so it lands on the same edge
  // as bus_out and holds whenever bus_out holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_par_q <= 1'b0;
    end else if (do_load) begin
      bus_par_q <= ^load_word;
    end
  end

  assign bif.bus_par = bus_par_q;
`endif

  assign bif.bus_out   = bus_out_q;
  assign bif.bus_valid = bus_valid_q;
  assign bif.bus_src   = bus_src_q;
  assign bif.grant     = grant_q;
  assign bif.sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_mux_arb.sv
// tb_bus_mux_arb
//   Scoreboard bench for bus_mux_arb. The driver applies inputs on the falling
//   edge, advances a behavioural model of the bus rules by one clock edge and
//   queues the expected outputs; a monitor pops one entry after each rising
//   edge and compares it with the DUT. Directed scenarios come first, then
//   randomized traffic with occasional resets.
module tb_bus_mux_arb;

  localparam int W     = 16;
  localparam int N     = 11;
  localparam int IDX_W = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bus_mux_arb_if #(.W(W), .N(N), .IDX_W(IDX_W)) bif ();

  bus_mux_arb #(.W(W), .N(N), .IDX_W(IDX_W)) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif)
  );

  typedef struct {
    logic [31:0] bus_out;
    logic [31:0] bus_valid;
    logic [31:0] bus_src;
    logic [31:0] grant;
    logic [31:0] sel_err;
  } exp_t;

  exp_t sb_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state: holder is -1 when nobody holds the bus.
  logic [W-1:0] m_out;
  logic         m_valid;
  int           m_src;
  int           m_holder;
  int           m_ptr;
  logic         m_err;

  logic         cur_mode;
  logic [N-1:0] cur_req;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] srcWord(input int k);
    return bif.src_data[k*W +: W];
  endfunction

  task automatic modelReset();
    m_out    = '0;
    m_valid  = 1'b0;
    m_src    = 0;
    m_holder = -1;
    m_ptr    = 0;
    m_err    = 1'b0;
  endtask

  // One clock edge of the bus rules, written from the behavioural description.
  task automatic modelStep(input logic mode_v, input logic [N-1:0] sel_v,
                           input logic [N-1:0] req_v, input logic hold_v,
                           input logic clr_v);
    int   ones;
    int   k;
    logic err_set;
    err_set = 1'b0;
    if (!mode_v) begin
      ones = 0;
      k    = 0;
      for (int i = 0; i < N; i++) begin
        if (sel_v[i]) begin
          ones++;
          k = i;
        end
      end
      if (ones == 1) begin
        m_out   = srcWord(k);
        m_src   = k;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (ones > 1) err_set = 1'b1;
      m_holder = -1;
    end else if (hold_v && m_holder >= 0 && req_v[m_holder]) begin
      m_out   = srcWord(m_holder);
      m_src   = m_holder;
      m_valid = 1'b1;
    end else if (req_v != '0) begin
      k = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (k < 0 && req_v[j]) k = j;
      end
      m_holder = k;
      m_out    = srcWord(k);
      m_src    = k;
      m_valid  = 1'b1;
      m_ptr    = (k + 1) % N;
    end else begin
      m_holder = -1;
      m_valid  = 1'b0;
    end
    if (err_set) m_err = 1'b1;
    else if (clr_v) m_err = 1'b0;
  endtask

  // Drive one cycle of inputs on the falling edge, update the model for the
  // coming rising edge and queue what the DUT must show after it. Sources are
  // random except an optional pinned source/word pair.
  task automatic applyStimulus(input logic rst_v, input logic mode_v,
                               input logic [N-1:0] sel_v, input logic [N-1:0] req_v,
                               input logic hold_v, input logic clr_v,
                               input int pin_idx, input logic [W-1:0] pin_word);
    exp_t e;
    logic [31:0] r;
    @(negedge clock);
    reset       = rst_v;
    bif.mode    = mode_v;
    bif.sel     = sel_v;
    bif.req     = req_v;
    bif.hold    = hold_v;
    bif.err_clr = clr_v;
    for (int k = 0; k < N; k++) begin
      r = $urandom;
      bif.src_data[k*W +: W] = r[W-1:0];
    end
    if (pin_idx >= 0) bif.src_data[pin_idx*W +: W] = pin_word;
    cur_mode = mode_v;
    cur_req  = req_v;
    if (rst_v) modelReset();
    else modelStep(mode_v, sel_v, req_v, hold_v, clr_v);
    e.bus_out   = 32'(m_out);
    e.bus_valid = 32'(m_valid);
    e.bus_src   = m_src;
    e.grant     = (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0;
    e.sel_err   = 32'(m_err);
    sb_q.push_back(e);
  endtask

  // Assert reset between edges and check that every output clears at once,
  // without waiting for a clock edge.
  task automatic resetMidCycle();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_bus_out",   32'(bif.bus_out),   32'd0);
    checkOutput("async_rst_bus_valid", 32'(bif.bus_valid), 32'd0);
    checkOutput("async_rst_bus_src",   32'(bif.bus_src),   32'd0);
    checkOutput("async_rst_grant",     32'(bif.grant),     32'd0);
    checkOutput("async_rst_sel_err",   32'(bif.sel_err),   32'd0);
`ifdef BUS_MUX_PARITY_EN
    checkOutput("async_rst_bus_par",   32'(bif.bus_par),   32'd0);
`endif
    modelReset();
  endtask

  function automatic logic [N-1:0] bit1(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Monitor: after every rising edge, compare the DUT with the next queued
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("bus_out",   32'(bif.bus_out),   e.bus_out);
        checkOutput("bus_valid", 32'(bif.bus_valid), e.bus_valid);
        checkOutput("bus_src",   32'(bif.bus_src),   e.bus_src);
        checkOutput("grant",     32'(bif.grant),     e.grant);
        checkOutput("sel_err",   32'(bif.sel_err),   e.sel_err);
`ifdef BUS_MUX_PARITY_EN
        checkOutput("bus_par",   32'(bif.bus_par),   32'(^e.bus_out[W-1:0]));
`endif
      end
    end
  end

  // Main stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0]  r;
    logic [N-1:0] sel_v;
    logic [N-1:0] req_v;
    logic         mode_v;
    reset       = 1'b1;
    bif.mode    = 1'b0;
    bif.sel     = '0;
    bif.req     = '0;
    bif.hold    = 1'b0;
    bif.err_clr = 1'b0;
    bif.src_data = '0;
    modelReset();
    cur_mode = 1'b0;
    cur_req  = '0;

    applyStimulus(1, 0, '0, '0, 0, 0, -1, '0);
    applyStimulus(1, 0, '0, '0, 0, 0, -1, '0);

    // Load 1234 then reset asynchronously in the middle of the cycle.
    applyStimulus(0, 0, bit1(3), '0, 0, 0, 3, 16'h1234);
    resetMidCycle();

    // Direct select of source 2, then idle, then a multi-hot select, then clear.
    applyStimulus(0, 0, bit1(2), '0, 0, 0, 2, 16'hABCD);
    applyStimulus(0, 0, '0, '0, 0, 0, -1, '0);
    applyStimulus(0, 0, 11'b000_0000_0101, '0, 0, 0, -1, '0);
    applyStimulus(0, 0, '0, '0, 0, 1, -1, '0);
    // Set and clear on the same edge: set must win.
    applyStimulus(0, 0, 11'b000_0000_0110, '0, 0, 1, -1, '0);
    applyStimulus(0, 0, '0, '0, 0, 1, -1, '0);
    // Highest source index.
    applyStimulus(0, 0, bit1(N-1), '0, 0, 0, -1, '0);
`ifdef BUS_MUX_PARITY_EN
    applyStimulus(0, 0, bit1(4), '0, 0, 0, 4, 16'h0007);
    applyStimulus(0, 0, bit1(4), '0, 0, 0, 4, 16'h0003);
`endif

    // Round robin from pointer 0 with requests 1,5,9 held four edges.
    applyStimulus(1, 0, '0, '0, 0, 0, -1, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, '0, bit1(1) | bit1(5) | bit1(9), 0, 0, -1, '0);
    // Source 5 wins, holds for three edges, then releases to 9.
    applyStimulus(0, 1, '0, bit1(5) | bit1(9), 0, 0, -1, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, '0, bit1(5) | bit1(9), 1, 0, -1, '0);
    applyStimulus(0, 1, '0, bit1(5) | bit1(9), 0, 0, -1, '0);
    // Holder drops its request while hold is high; wrap from N-1 to 0.
    applyStimulus(0, 1, '0, bit1(0) | bit1(N-1), 1, 0, -1, '0);
    applyStimulus(0, 1, '0, bit1(0) | bit1(N-1), 0, 0, -1, '0);
    applyStimulus(0, 1, '0, '0, 0, 0, -1, '0);
    // sel is ignored in mode 1.
    applyStimulus(0, 1, 11'b000_0000_0011, '0, 0, 0, -1, '0);

    // Randomized traffic.
    mode_v = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) mode_v = ~mode_v;
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       sel_v = '0;
        1, 2:    sel_v = bit1($urandom_range(0, N-1));
        default: sel_v = r[N-1:0];
      endcase
      r = $urandom & $urandom;
      if ($urandom_range(0, 2) == 0) req_v = cur_req;
      else req_v = r[N-1:0];
      if (c % 700 == 350) begin
        resetMidCycle();
      end else begin
        applyStimulus($urandom_range(0, 99) == 0, mode_v, sel_v, req_v,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, -1, '0);
      end
    end

    applyStimulus(0, 0, '0, '0, 0, 0, -1, '0);
    repeat (2) @(negedge clock);
    checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
